lsu_mem_master: RTL
===================

// Module: lsu_mem_master
// PURPOSE
//  Load/store initiator driving the byte-enabled word memory port (we, be[3:0], word addr, wdata, async rdata).
//  Accepts one RV32 load/store at a time from the core. Generates byte enables and lane-shifted store data.
//  Extracts and sign/zero-extends load data. Returns a one-cycle response pulse.
// PARAMETERS
//  ADDR_W   32  byte-address width on both sides
//  RESET_PC 0   unused by logic; kept for a uniform top-level parameter list
// PORTS
//  clk          in   1   single clock; all state changes on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  req_valid    in   1   core request present
//  req_ready    out  1   high only in IDLE; transfer = valid & ready
//  req_we       in   1   1=store, 0=load
//  req_funct3   in   3   RV32 funct3: LB0 LH1 LW2 LBU4 LHU5 / SB0 SH1 SW2
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned
//  resp_valid   out  1   one-cycle completion pulse; consumer must take it
//  resp_rdata   out  32  extended load data (0 for stores and errors)
//  resp_err     out  1   valid with resp_valid: illegal funct3 or unsupported misalignment
//  mem_we       out  1   memory write strobe
//  mem_be       out  4   byte enables
//  mem_addr     out  32  byte address to memory; [1:0] always 0
//  mem_wdata    out  32  lane-shifted store data
//  mem_rdata    in   32  combinational read data for mem_addr
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
//  Request fields are registered on acceptance. The core may change its inputs afterwards.
//  States:
//   IDLE -> ACC_LO on accept.
//   ACC_LO -> RESP, or -> ACC_HI for a split access (split only with the macro).
//   ACC_HI -> RESP.
//   RESP -> IDLE.
//  ACC_*: mem_addr={addr[31:2]+k,2'b00}, with k=0 in ACC_LO and k=1 in ACC_HI (word index wraps mod 2^30).
//  ACC_*: mem_be and mem_wdata are driven for that word. mem_we=req_we.
//  ACC_*: for loads, mem_rdata is sampled at the end of the same cycle.
//  Outside ACC_*, mem_we=0 and mem_be=0. mem_addr and mem_wdata hold their last value.
//  Byte enables, offset o=addr[1:0]: B -> 1<<o; H -> 3<<o; W -> 4'hF. Lanes above bit 3 go to ACC_HI.
//  Store data: wdata<<(8*o). Bits shifted past 31 go to lane 0 upward in ACC_HI.
//  Load data: bytes collected from the lanes are shifted down by o.
//   LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend.
//  RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err; req_ready=0.
//  Latency: accept at cycle N, resp_valid at N+2 (unsplit) or N+3 (split). Throughput: one request per 3 or 4 cycles.
//  Illegal funct3 (load 3,6,7; store >=3): no memory cycle at all, mem_we stays 0.
//   Goes IDLE->RESP with resp_err=1 and resp_rdata=0. Latency N+1.
//  Misalignment rule: H with o=1 stays inside one word. That case is legal in both builds (single access, be=4'b0110).
//  rst_n low mid-access: immediate return to reset values. No partial second write is issued after reset.
//  req_valid during ACC_*/RESP is ignored (req_ready=0).
// CONFIGURATION
//  LSU_MISALIGN_SPLIT_EN defined:
//   H with o=3 and W with o!=0 become two word accesses, ACC_LO then ACC_HI. resp_err=0.
//  Undefined:
//   Those cases take the error path: no memory cycle, resp_err=1. ACC_HI is unreachable and is optimized out.
//  Misaligned H with o=1 is legal in both builds.
// STRUCTURE
//  lsu_pkg holds:
//   funct3 localparams (F3_B/H/W/BU/HU).
//   State encoding (ST_IDLE, ST_ACC_LO, ST_ACC_HI, ST_RESP).
//   The byte-lane mask function.
//  Sub-module lsu_align (combinational):
//   Store side: funct3 and offset -> 8-bit lane mask and 64-bit shifted wdata.
//   Load side: 64-bit assembled read data and offset -> extended 32-bit result.
//  Top: FSM, request and response registers, read-data capture register for the low word.
// TESTING
//  SW 0x100, data 0xDEADBEEF -> one cycle mem_we=1, be=F, addr=0x100, wdata=DEADBEEF. resp_valid at N+2, err=0.
//  SB 0x103, data 0x000000A5 -> be=4'b1000, wdata=0xA5000000. A following LBU 0x103 returns 0x000000A5; LB 0x103 returns 0xFFFFFFA5.
//  Memory word 0x8001_7FFF at 0x200: LH 0x202 -> 0xFFFF8001; LHU 0x202 -> 0x00008001; LH 0x201 -> 0x0000017F (be=0110, legal).
//  LW 0x101 with macro: reads 0x100 then 0x104, response at N+3. Without macro: resp_err=1 at N+1, mem_we never asserted.
//  funct3=3 store -> resp_err=1, no mem_we. Back-to-back req_valid held high -> second accept only after RESP.
//  Split SW 0x106: assert rst_n=0 during ACC_LO -> mem_we drops immediately, no write to 0x108, resp_valid stays 0.

Source files
------------

// File: rtl/lsu_mem_master_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store memory master:
//   - RV32 funct3 encodings for the access size/sign
//   - FSM state encoding
//   - byte-lane mask helper (8 lanes = two consecutive words)
//   - funct3 legality check per direction
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC_LO = 2'd1,
        ST_ACC_HI = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

    // Lanes 0..3 belong to the addressed word, lanes 4..7 to the next word.
    // Only funct3[1:0] matters here: BU/HU share the size of B/H.
    function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces of the load/store memory master.
//   lsu_req_if : core request/response channel.
//     master modport = core side, slave modport = LSU side.
//     Handshake: a request transfers on a rising clk edge where
//     req_valid && req_ready are both high. resp_valid is a one-cycle pulse
//     with no back-pressure; the consumer must take it in that cycle.
//   lsu_mem_if : byte-enabled word memory port.
//     master modport = LSU side, slave modport = memory side.
//     mem_rdata is combinational for the current mem_addr; writes commit on
//     the rising edge where mem_we is high, per enabled byte lane.
// ---------------------------------------------------------------------------
interface lsu_req_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 32);
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );
    modport slave (
        input  mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_master_align.sv
// ---------------------------------------------------------------------------
// lsu_align : combinational lane alignment for the load/store master.
// Store side:
//   i_st_size  [1:0]  funct3[1:0] of the request (B/H/W)
//   i_st_off   [1:0]  byte offset within the word
//   i_st_wdata [31:0] right-aligned store data
//   o_st_mask  [7:0]  byte-lane mask over two consecutive words
//   o_st_wd64  [63:0] store data shifted into its lanes
// Load side:
//   i_ld_f3    [2:0]  funct3 of the load
//   i_ld_off   [1:0]  byte offset within the word
//   i_ld_data  [63:0] {high word, low word} as read from memory
//   o_ld_ext   [31:0] right-aligned, sign/zero-extended result
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_wdata,
    output logic [7:0]  o_st_mask,
    output logic [63:0] o_st_wd64,
    input  logic [2:0]  i_ld_f3,
    input  logic [1:0]  i_ld_off,
    input  logic [63:0] i_ld_data,
    output logic [31:0] o_ld_ext
);
    logic [31:0] w_ld_word;
    logic        w_unused_ld;

    assign o_st_mask = lane_mask(i_st_size, i_st_off);
    assign o_st_wd64 = {32'h0, i_st_wdata} << {i_st_off, 3'b000};

    // Right-align the addressed bytes; a word at offset 3 reaches lane 6 at
    // most, so lane 7 of the assembled data never contributes.
    always_comb begin
        case (i_ld_off)
            2'd0:    w_ld_word = i_ld_data[31:0];
            2'd1:    w_ld_word = i_ld_data[39:8];
            2'd2:    w_ld_word = i_ld_data[47:16];
            default: w_ld_word = i_ld_data[55:24];
        endcase
    end

    assign w_unused_ld = ^i_ld_data[63:56];

    always_comb begin
        case (i_ld_f3)
            F3_B:    o_ld_ext = {{24{w_ld_word[7]}}, w_ld_word[7:0]};
            F3_H:    o_ld_ext = {{16{w_ld_word[15]}}, w_ld_word[15:0]};
            F3_BU:   o_ld_ext = {24'h0, w_ld_word[7:0]};
            F3_HU:   o_ld_ext = {16'h0, w_ld_word[15:0]};
            default: o_ld_ext = w_ld_word;
        endcase
    end
endmodule

// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master : RV32 load/store initiator for a byte-enabled word memory.
// Accepts one request at a time, drives one (or two, for a split access)
// memory cycles, then pulses a one-cycle response.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req  (slave)      core request/response channel (lsu_req_if)
//   mem  (master)     word memory port (lsu_mem_if)
//   o_dbg_state       current FSM state
// Build option:
//   LSU_MISALIGN_SPLIT_EN  when defined, H at offset 3 and W at offset 1..3
//                          become two word accesses (ACC_LO then ACC_HI);
//                          otherwise they return resp_err without touching
//                          memory.
// Parameters: ADDR_W byte-address width; RESET_PC has no effect on logic.
// ---------------------------------------------------------------------------
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_req_if.slave   req,
    lsu_mem_if.master  mem,
    output lsu_state_t o_dbg_state
);
    lsu_state_t        r_state;
    logic              r_we;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [ADDR_W-3:0] r_widx;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [3:0]        r_be_hi;
    logic [31:0]       r_wd_hi;
    logic [31:0]       r_rd_lo;
    logic [ADDR_W-3:0] w_widx_hi;
`endif

    logic [7:0]        w_mask;
    logic [63:0]       w_wd64;
    logic [63:0]       w_ld64;
    logic [31:0]       w_ld_ext;
    logic              w_split;
    logic              w_legal;
    logic              w_unused;

    lsu_align u_align (
        .i_st_size  (req.req_funct3[1:0]),
        .i_st_off   (req.req_addr[1:0]),
        .i_st_wdata (req.req_wdata),
        .o_st_mask  (w_mask),
        .o_st_wd64  (w_wd64),
        .i_ld_f3    (r_f3),
        .i_ld_off   (r_off),
        .i_ld_data  (w_ld64),
        .o_ld_ext   (w_ld_ext)
    );

    // Any lane above 3 means the access crosses into the next word.
    assign w_split = |w_mask[7:4];

    always_comb begin
        w_legal = f3_legal(req.req_we, req.req_funct3);
`ifndef LSU_MISALIGN_SPLIT_EN
        if (w_split)
            w_legal = 1'b0;
`endif
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_widx_hi = r_widx + {{(ADDR_W-3){1'b0}}, 1'b1};
    // In ACC_HI the low word was captured last cycle; the live read is the
    // high word.
    assign w_ld64    = (r_state == ST_ACC_HI) ? {mem.mem_rdata, r_rd_lo}
                                              : {32'h0, mem.mem_rdata};
    assign w_unused  = ^RESET_PC;
`else
    assign w_ld64    = {32'h0, mem.mem_rdata};
    assign w_unused  = ^{RESET_PC, w_wd64[63:32]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_f3         <= 3'd0;
            r_off        <= 2'd0;
            r_widx       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 4'h0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_be_hi      <= 4'h0;
            r_wd_hi      <= 32'h0;
            r_rd_lo      <= 32'h0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // req_ready is high throughout IDLE, so valid alone accepts.
                    if (req.req_valid) begin
                        r_we   <= req.req_we;
                        r_f3   <= req.req_funct3;
                        r_off  <= req.req_addr[1:0];
                        r_widx <= req.req_addr[ADDR_W-1:2];
`ifdef LSU_MISALIGN_SPLIT_EN
                        r_be_hi <= w_mask[7:4];
                        r_wd_hi <= w_wd64[63:32];
`endif
                        if (w_legal) begin
                            r_state     <= ST_ACC_LO;
                            r_mem_we    <= req.req_we;
                            r_mem_be    <= w_mask[3:0];
                            r_mem_addr  <= {req.req_addr[ADDR_W-1:2], 2'b00};
                            r_mem_wdata <= w_wd64[31:0];
                        end else begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0;
                        end
                    end
                end
                ST_ACC_LO: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (|r_be_hi) begin
                        r_state     <= ST_ACC_HI;
                        r_rd_lo     <= mem.mem_rdata;
                        r_mem_be    <= r_be_hi;
                        r_mem_addr  <= {w_widx_hi, 2'b00};
                        r_mem_wdata <= r_wd_hi;
                    end else
`endif
                    begin
                        r_state      <= ST_RESP;
                        r_mem_we     <= 1'b0;
                        r_mem_be     <= 4'h0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_we ? 32'h0 : w_ld_ext;
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ST_ACC_HI: begin
                    r_state      <= ST_RESP;
                    r_mem_we     <= 1'b0;
                    r_mem_be     <= 4'h0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= r_we ? 32'h0 : w_ld_ext;
                end
`endif
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_we <= 1'b0;
                    r_mem_be <= 4'h0;
                end
            endcase
        end
    end

    assign req.req_ready  = (r_state == ST_IDLE);
    assign req.resp_valid = r_resp_valid;
    assign req.resp_rdata = r_resp_rdata;
    assign req.resp_err   = r_resp_err;
    assign mem.mem_we     = r_mem_we;
    assign mem.mem_be     = r_mem_be;
    assign mem.mem_addr   = r_mem_addr;
    assign mem.mem_wdata  = r_mem_wdata;
    assign o_dbg_state    = r_state;
endmodule
